// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with a data-side streak limit.
// Optional bus timeout: define MEM_ARB_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int STREAK_MAX     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_BUSY  = 2'd1,
        IF_BUSY = 2'd2
    } state_t;

    localparam int STREAK_W = (STREAK_MAX < 2) ? 1 : $clog2(STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);

    if (STREAK_MAX < 1) begin : g_bad_streak
        $error("mem_arbiter: STREAK_MAX must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t              state, state_nxt;
    logic [STREAK_W-1:0] d_streak, d_streak_nxt;

    logic        if_gnt_nxt, if_valid_nxt, d_gnt_nxt, d_valid_nxt;
    logic [31:0] if_rdata_nxt, d_rdata_nxt;
    logic        mem_req_nxt, mem_we_nxt, busy_nxt;
    logic [31:0] mem_addr_nxt, mem_wdata_nxt;

    logic streak_full, grant_d, grant_if;

    // Data wins unless it has already taken STREAK_MAX grants in a row over a waiting fetch.
    assign streak_full = (d_streak == STREAK_TOP);
    assign grant_d     = d_req && !(if_req && streak_full);
    assign grant_if    = if_req && !grant_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            expire, err_nxt, err_q;

    assign expire = (to_cnt == TO_LAST);
    assign err    = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        d_streak_nxt  = d_streak;
        if_gnt_nxt    = 1'b0;
        d_gnt_nxt     = 1'b0;
        if_valid_nxt  = 1'b0;
        d_valid_nxt   = 1'b0;
        if_rdata_nxt  = if_rdata;
        d_rdata_nxt   = d_rdata;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        busy_nxt      = busy;
`ifdef MEM_ARB_TIMEOUT_EN
        to_cnt_nxt    = to_cnt;
        err_nxt       = 1'b0;
`endif

        case (state)
            IDLE: begin
                mem_req_nxt = 1'b0;
                busy_nxt    = 1'b0;
                if (grant_d) begin
                    state_nxt     = D_BUSY;
                    d_gnt_nxt     = 1'b1;
                    mem_req_nxt   = 1'b1;
                    busy_nxt      = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    if (if_req) begin
                        if (!streak_full) begin
                            d_streak_nxt = d_streak + STREAK_W'(1);
                        end
                    end else begin
                        d_streak_nxt = '0;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    to_cnt_nxt = '0;
`endif
                end else if (grant_if) begin
                    state_nxt     = IF_BUSY;
                    if_gnt_nxt    = 1'b1;
                    mem_req_nxt   = 1'b1;
                    busy_nxt      = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    d_streak_nxt  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    to_cnt_nxt = '0;
`endif
                end
            end

            D_BUSY, IF_BUSY: begin
                if (mem_ack) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    if (state == D_BUSY) begin
                        d_valid_nxt = 1'b1;
                        d_rdata_nxt = mem_rdata;
                    end else begin
                        if_valid_nxt = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // A late ack on the expiry edge still completes normally (checked first above).
                else if (expire) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    err_nxt     = 1'b1;
                    if (state == D_BUSY) begin
                        d_valid_nxt = 1'b1;
                        d_rdata_nxt = '0;
                    end else begin
                        if_valid_nxt = 1'b1;
                        if_rdata_nxt = '0;
                    end
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
`endif
            end

            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

    // Reset clears every output, including read data, so a dropped transaction leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            d_streak  <= '0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            d_streak  <= d_streak_nxt;
            if_gnt    <= if_gnt_nxt;
            d_gnt     <= d_gnt_nxt;
            if_valid  <= if_valid_nxt;
            d_valid   <= d_valid_nxt;
            if_rdata  <= if_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= busy_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt    <= to_cnt_nxt;
            err_q     <= err_nxt;
`endif
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, number of busy cycles without mem_ack before abort (used only when MEM_ARB_TIMEOUT_EN is defined).
REQ-002 Parameter: STREAK_MAX, 2, maximum consecutive data-port grants while fetch is pending.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 if_req  in  1  fetch read request; if_addr  in  32  fetch address.
REQ-006 if_gnt  out  1  fetch request accepted; if_valid  out  1  fetch response strobe; if_rdata  out  32  fetch read data.
REQ-007 d_req  in  1  data request; d_we  in  1  write enable; d_addr  in  32  data address; d_wdata  in  32  write data.
REQ-008 d_gnt  out  1  data request accepted; d_valid  out  1  data response strobe; d_rdata  out  32  data read data.
REQ-009 mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32: shared memory port command.
REQ-010 mem_rdata  in  32; mem_ack  in  1: memory completion.
REQ-011 busy  out  1  transaction in flight; err  out  1  timeout-abort strobe.

Function
REQ-012 FSM states: IDLE, D_BUSY, IF_BUSY; all outputs registered.
REQ-013 IDLE, rising edge N with any request high -> grant chosen, request fields latched, state moves to the granted BUSY state; in cycle N+1: x_gnt=1 (one cycle), mem_req=1, mem_addr/mem_we/mem_wdata = latched values, busy=1.
REQ-014 Fetch grant drives mem_we=0 and mem_wdata=0.
REQ-015 Priority: data over fetch, except when d_streak==STREAK_MAX with both requests high -> fetch granted.
REQ-016 d_streak increments on a data grant made while if_req is high; clears on any fetch grant or on a data grant with if_req low; saturates at STREAK_MAX.
REQ-017 Requesters hold req and fields stable until gnt; req dropped before grant = withdrawn, no response generated.
REQ-018 mem_req and command fields held constant until mem_ack is sampled high in a BUSY state.
REQ-019 mem_ack sampled at edge M -> cycle M+1: mem_req=0, busy=0, x_valid=1 (one cycle), x_rdata=mem_rdata captured at M (writes return mem_rdata as captured, value don't-care to requester); state=IDLE.
REQ-020 IDLE arbitrates at edge M+1 at the earliest; minimum one cycle between consecutive mem_req pulses; latency from request sample to response = 2 + memory wait cycles.
REQ-021 mem_ack while IDLE is ignored.
REQ-022 x_rdata holds its last value between responses.

Reset
REQ-023 rst low at a rising edge -> state=IDLE, d_streak=0, timeout counter=0; all outputs (gnt, valid, rdata, mem_*, busy, err) = 0 from the following cycle.
REQ-024 Reset mid-transaction drops the transaction: no valid strobe, no err, and a mem_ack arriving during or after reset is ignored.

Configuration
REQ-025 Macro MEM_ARB_TIMEOUT_EN defined: counter clears on entering BUSY and increments each BUSY cycle without mem_ack; on reaching TIMEOUT_CYCLES -> next cycle mem_req=0, x_valid=1, x_rdata=0, err=1 (one cycle), state=IDLE.
REQ-026 mem_ack on the same edge as expiry -> normal completion, err stays 0.
REQ-027 Macro undefined: no counter, err tied 0, arbiter waits indefinitely for mem_ack.

Verification
REQ-028 Single fetch: if_req=1, if_addr=0x100, mem_ack after 3 wait cycles with mem_rdata=0x00500093 -> if_gnt one cycle, mem_addr=0x100, mem_we=0, if_valid one cycle with if_rdata=0x00500093.
REQ-029 Simultaneous requests: if_req and d_req (write 0xCAFEF00D to 0x2000) in the same cycle -> data granted first; fetch granted in the IDLE cycle after d_valid.
REQ-030 Starvation guard: d_req held continuously with if_req high, mem_ack immediate -> grant order D, D, IF, D, D, IF.
REQ-031 Reset mid-op: rst low during D_BUSY, mem_ack arrives the cycle after -> no d_valid, all outputs 0, next request is served normally.
REQ-032 Timeout (macro defined, TIMEOUT_CYCLES=16): d_req read, mem_ack never asserted -> 16 busy cycles, then d_valid=1, err=1, d_rdata=0; a second run with mem_ack on the expiry edge -> err=0.
REQ-033 Withdrawn request: if_req pulsed for one cycle while D_BUSY -> no if_gnt and no if_valid.
